bcp_clause_scan: RTL

Clause-scan stage of the hardware BCP engine, directly downstream of `clause_table`. On a scan request it walks a contiguous range of clause words in `clause_table`. It classifies each clause against the current variable assignment as satisfied, unresolved, unit or conflicting. Unit clauses are emitted as implications over a valid/ready port to the trail/assignment stage; a conflict aborts the scan.

---
 rtl/bcp_clause_scan.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bcp_clause_scan.sv
// bcp_clause_scan: clause-scan stage of the BCP engine.
// Walks a contiguous range of clause_table words and classifies each clause
// against the current assignment. Unit clauses leave as implications over a
// valid/ready port, and a conflicting clause aborts the scan.
// Optional feature macro: BCP_DEDUP_EN. When it is defined, an implication
// that repeats an earlier one in the same scan is dropped. An implication that
// contradicts an earlier one is reported as a conflict at that clause.
module bcp_clause_scan #(
    parameter int VAR_W  = 4,
    parameter int LITS   = 3,
    parameter int ADDR_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [ADDR_W-1:0]         start_addr_i,
    input  logic [ADDR_W:0]           start_count_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      mem_en_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    input  logic [LITS*(VAR_W+2)-1:0] mem_dout_i,
    input  logic [(2**VAR_W)-1:0]     asg_set_i,
    input  logic [(2**VAR_W)-1:0]     asg_val_i,
    output logic                      imp_valid_o,
    input  logic                      imp_ready_i,
    output logic [VAR_W-1:0]          imp_var_o,
    output logic                      imp_val_o,
    output logic                      conflict_o,
    output logic [ADDR_W-1:0]         conflict_addr_o
);

    localparam int LIT_W = VAR_W + 2;
    localparam int NVARS = 2 ** VAR_W;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] EVAL  = 3'd2;
    localparam logic [2:0] PUSH  = 3'd3;
    localparam logic [2:0] FIN   = 3'd4;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_ZERO = 0;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W:0]   rem_q, rem_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              memEn_q, memEn_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic              impValid_q, impValid_d;
    logic [VAR_W-1:0]  impVar_q, impVar_d;
    logic              impVal_q, impVal_d;
    logic              conflict_q, conflict_d;
    logic [ADDR_W-1:0] conflictAddr_q, conflictAddr_d;

`ifdef BCP_DEDUP_EN
    logic [NVARS-1:0]  impMask_q, impMask_d;
    logic [NVARS-1:0]  impMval_q, impMval_d;
`endif

    logic [LIT_W-1:0]  lit;
    logic [VAR_W-1:0]  litVar;
    logic              anyTrue;
    logic              seenUnas;
    logic              multiUnas;
    logic [VAR_W-1:0]  unitVar;
    logic              unitVal;
    logic              advance;
    logic              abort;

    // Classify the clause word on mem_dout_i: any true literal, and how many are unassigned
    always_comb begin
        lit       = '0;
        litVar    = '0;
        anyTrue   = 1'b0;
        seenUnas  = 1'b0;
        multiUnas = 1'b0;
        unitVar   = '0;
        unitVal   = 1'b0;
        for (int i = 0; i < LITS; i++) begin
            lit    = mem_dout_i[i*LIT_W +: LIT_W];
            litVar = lit[VAR_W-1:0];
            if (lit[LIT_W-1]) begin
                if (!asg_set_i[litVar]) begin
                    if (seenUnas) begin
                        multiUnas = 1'b1;
                    end
                    seenUnas = 1'b1;
                    unitVar  = litVar;
                    unitVal  = ~lit[VAR_W];
                end else if (asg_val_i[litVar] != lit[VAR_W]) begin
                    anyTrue = 1'b1;
                end
            end
        end
    end

    // Next-state logic: walk the clause range, then derive the registered outputs from the next state
    always_comb begin
        state_d        = state_q;
        cur_d          = cur_q;
        rem_d          = rem_q;
        impVar_d       = impVar_q;
        impVal_d       = impVal_q;
        conflictAddr_d = conflictAddr_q;
        advance        = 1'b0;
        abort          = 1'b0;
`ifdef BCP_DEDUP_EN
        impMask_d      = impMask_q;
        impMval_d      = impMval_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    cur_d          = start_addr_i;
                    rem_d          = start_count_i;
                    conflictAddr_d = '0;
`ifdef BCP_DEDUP_EN
                    impMask_d      = '0;
                    impMval_d      = '0;
`endif
                    state_d        = (start_count_i == CNT_ZERO) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                state_d = EVAL;
            end
            EVAL: begin
                if (anyTrue) begin
                    advance = 1'b1;
                end else if (!seenUnas) begin
                    abort = 1'b1;
                end else if (multiUnas) begin
                    advance = 1'b1;
                end else begin
`ifdef BCP_DEDUP_EN
                    if (impMask_q[unitVar]) begin
                        if (impMval_q[unitVar] == unitVal) begin
                            advance = 1'b1;
                        end else begin
                            abort = 1'b1;
                        end
                    end else begin
                        impMask_d[unitVar] = 1'b1;
                        impMval_d[unitVar] = unitVal;
                        impVar_d           = unitVar;
                        impVal_d           = unitVal;
                        state_d            = PUSH;
                    end
`else
                    impVar_d = unitVar;
                    impVal_d = unitVal;
                    state_d  = PUSH;
`endif
                end
            end
            PUSH: begin
                if (imp_ready_i) begin
                    advance = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d        = FIN;
            conflictAddr_d = cur_q;
        end
        if (advance) begin
            cur_d   = cur_q + ADDR_ONE;
            rem_d   = rem_q - CNT_ONE;
            state_d = (rem_q == CNT_ONE) ? FIN : ISSUE;
        end

        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FIN);
        conflict_d = abort;
        memEn_d    = (state_d == ISSUE);
        memAddr_d  = (state_d == ISSUE) ? cur_d : memAddr_q;
        impValid_d = (state_d == PUSH);
    end

    // State and output registers; reset drops any scan and pending implication at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cur_q          <= '0;
            rem_q          <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            memEn_q        <= 1'b0;
            memAddr_q      <= '0;
            impValid_q     <= 1'b0;
            impVar_q       <= '0;
            impVal_q       <= 1'b0;
            conflict_q     <= 1'b0;
            conflictAddr_q <= '0;
`ifdef BCP_DEDUP_EN
            impMask_q      <= '0;
            impMval_q      <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cur_q          <= cur_d;
            rem_q          <= rem_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            memEn_q        <= memEn_d;
            memAddr_q      <= memAddr_d;
            impValid_q     <= impValid_d;
            impVar_q       <= impVar_d;
            impVal_q       <= impVal_d;
            conflict_q     <= conflict_d;
            conflictAddr_q <= conflictAddr_d;
`ifdef BCP_DEDUP_EN
            impMask_q      <= impMask_d;
            impMval_q      <= impMval_d;
`endif
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign mem_en_o        = memEn_q;
    assign mem_addr_o      = memAddr_q;
    assign imp_valid_o     = impValid_q;
    assign imp_var_o       = impVar_q;
    assign imp_val_o       = impVal_q;
    assign conflict_o      = conflict_q;
    assign conflict_addr_o = conflictAddr_q;

endmodule
